// File: rtl/fim_fifo_rd_stream_pkg.sv
// Shared constants for the FIFO read-side stream adapter: occupancy encoding
// of the two-entry output buffer and its depth.
package fim_fifo_rd_stream_pkg;

  localparam logic [1:0] OCC_EMPTY   = 2'd0;
  localparam logic [1:0] OCC_ONE     = 2'd1;
  localparam logic [1:0] OCC_FULL    = 2'd2;
  localparam int         BUF_ENTRIES = 2;

endpackage

// File: rtl/fim_fifo_rd_stream.sv
// FIFO read port (1-cycle read latency) to valid/ready stream, via a 2-entry buffer.
// Optional saturating beat/stall counters are built when FIM_FIFO_RD_STREAM_STATS_EN is defined.
module fim_fifo_rd_stream
  import fim_fifo_rd_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int STAT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  r_empty,
  input  logic                  r_valid,
  input  logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_req,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic                  err,
  output logic [STAT_WIDTH-1:0] beat_cnt,
  output logic [STAT_WIDTH-1:0] stall_cnt
);

  logic [1:0]            occ;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] buf0;
  logic [DATA_WIDTH-1:0] buf1;

  logic                  pop;
  logic                  wr;
  logic                  overrun;
  logic                  spurious;
  logic [2:0]            committed;

  assign pop       = out_valid & out_ready;
  // Slots already promised (held + in flight) after this cycle's pop; never exceeds 3.
  assign committed = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
  assign r_req     = ~r_empty & ~err & (committed < 3'(BUF_ENTRIES));

  assign spurious  = r_valid & ~inflight;
  assign overrun   = r_valid & (occ == OCC_FULL) & ~pop;
  assign wr        = r_valid & ~overrun;

  assign out_valid = (occ != OCC_EMPTY);
  assign out_data  = buf0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ      <= OCC_EMPTY;
      inflight <= 1'b0;
      err      <= 1'b0;
      buf0     <= '0;
      buf1     <= '0;
    end else begin
      inflight <= r_req;
      occ      <= occ + {1'b0, wr} - {1'b0, pop};
      if (spurious | overrun) err <= 1'b1;
      // New word lands in the first free slot once the pop has been applied.
      if (pop) begin
        if (occ == OCC_FULL) begin
          buf0 <= buf1;
          if (wr) buf1 <= r_data;
        end else if (wr) begin
          buf0 <= r_data;
        end
      end else if (wr) begin
        if (occ == OCC_EMPTY) buf0 <= r_data;
        else                  buf1 <= r_data;
      end
    end
  end

`ifdef FIM_FIFO_RD_STREAM_STATS_EN
  function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [STAT_WIDTH-1:0] beat_q;
  logic [STAT_WIDTH-1:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_q  <= '0;
      stall_q <= '0;
    end else begin
      if (pop)                    beat_q  <= sat_inc(beat_q);
      if (out_valid & ~out_ready) stall_q <= sat_inc(stall_q);
    end
  end

  assign beat_cnt  = beat_q;
  assign stall_cnt = stall_q;
`else
  assign beat_cnt  = '0;
  assign stall_cnt = '0;
`endif

endmodule
